ps2_keycode_rx: RTL and testbench
=================================

// Module: ps2_keycode_rx
// PURPOSE
//  Keycode source for the motion logic: receives PS/2 (scan set 2) frames from a keyboard,
//  tracks make/break/extended prefixes, translates to USB HID usage codes and presents a held
//  8-bit keycode (0x00 = no key). Sits between the keyboard pins and the ball/motion block.
// PARAMETERS
//  SYNC_STAGES     2       flip-flop stages synchronising ps2_clk and ps2_data into Clk domain
//  TIMEOUT_CYCLES  100000  Clk cycles without a ps2_clk falling edge that abort a partial frame
// PORTS
//  Clk            in   1  system clock (one clock domain)
//  Reset_n        in   1  asynchronous, active-low reset
//  ps2_clk        in   1  raw PS/2 clock from keyboard (asynchronous, idle high)
//  ps2_data       in   1  raw PS/2 data from keyboard (asynchronous, idle high)
//  keycode        out  8  HID usage code of currently held key; 0x00 when none
//  keycode_valid  out  1  one-Clk pulse on every change of keycode
//  frame_err      out  1  one-Clk pulse on parity/start/stop error or timeout
// BEHAVIOUR
//  Reset (async, Reset_n=0): keycode=0x00, keycode_valid=0, frame_err=0, FSM=IDLE,
//   bit count=0, timeout count=0, break_pend=0, ext_pend=0, sync chains all 1s.
//  Edge detect: falling edge = synced ps2_clk 1 -> 0; ps2_data sampled on that Clk cycle.
//  Frame FSM (11-bit frame, LSB first): IDLE -> DATA -> PARITY -> STOP -> IDLE.
//   IDLE:   edge with data=0 -> DATA, bitcnt=0; edge with data=1 -> frame_err, stay IDLE.
//   DATA:   shift data into byte[bitcnt]; after 8th bit -> PARITY.
//   PARITY: check odd parity over 8 data + parity bit; remember result -> STOP.
//   STOP:   data=1 and parity ok -> byte_strobe (1 cycle) with byte; else frame_err. -> IDLE.
//  Timeout: counter cleared on each falling edge and in IDLE; in non-IDLE state reaching
//   TIMEOUT_CYCLES-1 -> frame_err pulse, IDLE, partial byte discarded.
//  Decoder (acts on byte_strobe, registered, updates the following cycle):
//   0xE0 -> ext_pend=1.  0xF0 -> break_pend=1.  Other byte b -> event, then clear both flags.
//   ext_pend=1 events ignored (extended keys unmapped). hid=map(b); hid==0x00 -> ignored.
//   Make:  hid != keycode -> keycode=hid, keycode_valid pulse; typematic repeat -> no change.
//   Break: hid == keycode -> keycode=0x00, keycode_valid pulse; other key released -> no change.
//  frame_err also clears break_pend and ext_pend (resynchronise at next prefix/make).
//  Latency: keycode changes exactly 2 Clk cycles after the stop-bit edge is detected
//   (cycle 1 byte_strobe, cycle 2 keycode/keycode_valid registered).
//  Simultaneous: edge and timeout same cycle -> edge wins. Reset_n mid-frame -> full reset.
//  Mapping (set 2 -> HID): A..Z letters (0x1C->0x04 A, 0x32 B, 0x21 C, 0x23->0x07 D, ...,
//   0x1D->0x1A W, 0x1B->0x16 S, 0x1A->0x1D Z), 0x29->0x2C space, 0x76->0x29 esc; others 0x00.
// STRUCTURE
//  ps2_pkg: frame_state_t enum (IDLE, DATA, PARITY, STOP), PS2_EXT=8'hE0, PS2_BREAK=8'hF0,
//   function set2_to_hid(input [7:0]) returning [7:0] (single mapping table, shared w/ benches).
//  Sub-module ps2_frame_rx: sync, edge detect, FSM, parity, timeout -> byte, byte_strobe,
//   frame_err. Top ps2_keycode_rx: prefix flags, mapping, held-keycode register.
// TESTING  (bench drives PS/2 frames at ~12.5 kHz, checks ports in Clk domain)
//  Reset: Reset_n=0 mid-frame -> keycode=0x00, pulses 0; next clean frame decodes normally.
//  Make 0x1D (W) -> keycode=0x1A, one keycode_valid pulse, exactly 2 Clk after stop edge.
//  0x1D,0x1D,0x1D (typematic) then F0 1D -> keycode 0x1A once, then 0x00; exactly 2 pulses.
//  Make 0x1C (A), make 0x23 (D), break F0 1C -> keycode 0x04, 0x07, stays 0x07 (no pulse).
//  Bad parity on 0x1B frame -> frame_err pulse, keycode unchanged; E0 75 -> no change.
//  Stop ps2_clk after 5 data bits for TIMEOUT_CYCLES -> frame_err, next frame 0x1B -> 0x16.

Source files
------------

// File: rtl/ps2_keycode_rx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_keycode_rx_pkg
// Shared definitions for the PS/2 keycode receiver:
//   - frame_state_t and its state constants for the frame FSM
//   - PS/2 scan set 2 prefix bytes (extended, break)
//   - odd_parity_ok(): odd-parity check over a data byte plus its parity bit
//   - set2_to_hid(): the scan set 2 -> USB HID usage translation table
// ---------------------------------------------------------------------------
package ps2_keycode_rx_pkg;

    typedef logic [1:0] frame_state_t;

    localparam frame_state_t ST_IDLE   = 2'd0;
    localparam frame_state_t ST_DATA   = 2'd1;
    localparam frame_state_t ST_PARITY = 2'd2;
    localparam frame_state_t ST_STOP   = 2'd3;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] HID_NONE  = 8'h00;

    // True when the nine bits together carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Letters, space and escape only; every other scan code maps to HID_NONE.
    function automatic logic [7:0] set2_to_hid(input logic [7:0] sc);
        logic [7:0] hid;
        case (sc)
            8'h1C:   hid = 8'h04; // A
            8'h32:   hid = 8'h05; // B
            8'h21:   hid = 8'h06; // C
            8'h23:   hid = 8'h07; // D
            8'h24:   hid = 8'h08; // E
            8'h2B:   hid = 8'h09; // F
            8'h34:   hid = 8'h0A; // G
            8'h33:   hid = 8'h0B; // H
            8'h43:   hid = 8'h0C; // I
            8'h3B:   hid = 8'h0D; // J
            8'h42:   hid = 8'h0E; // K
            8'h4B:   hid = 8'h0F; // L
            8'h3A:   hid = 8'h10; // M
            8'h31:   hid = 8'h11; // N
            8'h44:   hid = 8'h12; // O
            8'h4D:   hid = 8'h13; // P
            8'h15:   hid = 8'h14; // Q
            8'h2D:   hid = 8'h15; // R
            8'h1B:   hid = 8'h16; // S
            8'h2C:   hid = 8'h17; // T
            8'h3C:   hid = 8'h18; // U
            8'h2A:   hid = 8'h19; // V
            8'h1D:   hid = 8'h1A; // W
            8'h22:   hid = 8'h1B; // X
            8'h35:   hid = 8'h1C; // Y
            8'h1A:   hid = 8'h1D; // Z
            8'h29:   hid = 8'h2C; // space
            8'h76:   hid = 8'h29; // escape
            default: hid = HID_NONE;
        endcase
        return hid;
    endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// ---------------------------------------------------------------------------
// ps2_keycode_rx_if
// Bundles the keyboard pins and the keycode result bus.
//   ps2_clk, ps2_data           : raw PS/2 lines (asynchronous, idle high)
//   keycode                     : HID usage of the held key, 0x00 when none
//   keycode_valid               : one-cycle pulse on each keycode change
//   frame_err                   : one-cycle pulse on a bad or aborted frame
// Modports:
//   master : keyboard / consumer side - drives the PS/2 lines, reads results
//   slave  : the receiver - reads the PS/2 lines, drives the results
// ---------------------------------------------------------------------------
interface ps2_keycode_rx_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       keycode_valid;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  keycode,
        input  keycode_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output keycode,
        output keycode_valid,
        output frame_err
    );

endinterface

// File: rtl/ps2_keycode_rx_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_keycode_rx_frame_rx
// PS/2 frame receiver: synchronises the raw lines, detects ps2_clk falling
// edges, walks the 11-bit frame (start, 8 data LSB first, odd parity, stop)
// and aborts a stalled frame after TIMEOUT_CYCLES.
// Ports:
//   Clk, Reset_n   : system clock, asynchronous active-low reset
//   ps2_clk/data   : raw keyboard lines
//   rx_byte        : last good byte, valid while byte_strobe is high
//   byte_strobe    : one-cycle pulse per good frame
//   frame_err      : one-cycle pulse on start/parity/stop error or timeout
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module ps2_keycode_rx_frame_rx
    import ps2_keycode_rx_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_strobe,
    output logic       frame_err
);

    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;
    logic                   fall_s;
    logic                   data_s;

    frame_state_t           state_r;
    logic [2:0]             bitcnt_r;
    logic [7:0]             shift_r;
    logic                   parity_ok_r;
    logic [TMO_W-1:0]       tmo_cnt_r;
    logic [7:0]             rx_byte_r;
    logic                   byte_strobe_r;
    logic                   frame_err_r;

    // Synchronise both lines and keep the previous synced clock for edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_sync_r  <= {SYNC_STAGES{1'b1}};
            data_sync_r <= {SYNC_STAGES{1'b1}};
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
            data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
            clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    assign fall_s = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
    assign data_s = data_sync_r[SYNC_STAGES-1];

    // Frame FSM, parity check and stall timeout; a falling edge always beats the timeout.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r       <= ST_IDLE;
            bitcnt_r      <= 3'd0;
            shift_r       <= 8'h00;
            parity_ok_r   <= 1'b0;
            tmo_cnt_r     <= '0;
            rx_byte_r     <= 8'h00;
            byte_strobe_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            byte_strobe_r <= 1'b0;
            frame_err_r   <= 1'b0;
            if (fall_s) begin
                tmo_cnt_r <= '0;
                case (state_r)
                    ST_IDLE: begin
                        if (!data_s) begin
                            state_r  <= ST_DATA;
                            bitcnt_r <= 3'd0;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        shift_r[bitcnt_r] <= data_s;
                        if (bitcnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end else begin
                            bitcnt_r <= bitcnt_r + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        parity_ok_r <= odd_parity_ok(shift_r, data_s);
                        state_r     <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (data_s && parity_ok_r) begin
                            rx_byte_r     <= shift_r;
                            byte_strobe_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end else if (state_r == ST_IDLE) begin
                tmo_cnt_r <= '0;
            end else if (tmo_cnt_r == TMO_LAST) begin
                // Stalled mid-frame: drop the partial byte and resynchronise.
                frame_err_r <= 1'b1;
                state_r     <= ST_IDLE;
                tmo_cnt_r   <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
        end
    end

    assign rx_byte     = rx_byte_r;
    assign byte_strobe = byte_strobe_r;
    assign frame_err   = frame_err_r;

endmodule

// File: rtl/ps2_keycode_rx.sv
// ---------------------------------------------------------------------------
// ps2_keycode_rx
// Keycode source for the motion logic. Receives PS/2 scan set 2 bytes,
// tracks the extended (E0) and break (F0) prefixes, translates the scan code
// to a HID usage and holds the code of the currently pressed key.
// Ports:
//   Clk, Reset_n : system clock, asynchronous active-low reset
//   bus (slave)  : ps2_clk/ps2_data in; keycode, keycode_valid, frame_err out
// Only one key is tracked: a new make replaces the held code, and a break
// clears it only when it releases the key currently held.
// ---------------------------------------------------------------------------
module ps2_keycode_rx
    import ps2_keycode_rx_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic            Clk,
    input  logic            Reset_n,
    ps2_keycode_rx_if.slave bus
);

    logic [7:0] rx_byte_s;
    logic       byte_strobe_s;
    logic       frame_err_s;
    logic [7:0] hid_s;

    logic       ext_pend_r;
    logic       break_pend_r;
    logic [7:0] keycode_r;
    logic       keycode_valid_r;

    ps2_keycode_rx_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .ps2_clk     (bus.ps2_clk),
        .ps2_data    (bus.ps2_data),
        .rx_byte     (rx_byte_s),
        .byte_strobe (byte_strobe_s),
        .frame_err   (frame_err_s)
    );

    assign hid_s = set2_to_hid(rx_byte_s);

    // Prefix tracking and held-keycode update, one cycle after each received byte.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ext_pend_r      <= 1'b0;
            break_pend_r    <= 1'b0;
            keycode_r       <= HID_NONE;
            keycode_valid_r <= 1'b0;
        end else begin
            keycode_valid_r <= 1'b0;
            if (frame_err_s) begin
                // A lost byte makes any pending prefix meaningless.
                ext_pend_r   <= 1'b0;
                break_pend_r <= 1'b0;
            end else if (byte_strobe_s) begin
                if (rx_byte_s == PS2_EXT) begin
                    ext_pend_r <= 1'b1;
                end else if (rx_byte_s == PS2_BREAK) begin
                    break_pend_r <= 1'b1;
                end else begin
                    ext_pend_r   <= 1'b0;
                    break_pend_r <= 1'b0;
                    // Extended keys and unmapped codes never touch the held key.
                    if (!ext_pend_r && (hid_s != HID_NONE)) begin
                        if (break_pend_r) begin
                            if (hid_s == keycode_r) begin
                                keycode_r       <= HID_NONE;
                                keycode_valid_r <= 1'b1;
                            end
                        end else if (hid_s != keycode_r) begin
                            keycode_r       <= hid_s;
                            keycode_valid_r <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.keycode       = keycode_r;
    assign bus.keycode_valid = keycode_valid_r;
    assign bus.frame_err     = frame_err_s;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_keycode_rx
// Directed bench: drives PS/2 frames (40 Clk cycles per bit) into
// ps2_keycode_rx and checks keycode, keycode_valid and frame_err in the Clk
// domain, sampling on the falling Clk edge.
// ---------------------------------------------------------------------------
module tb_ps2_keycode_rx;

    localparam int SYNC_STAGES    = 2;
    localparam int TIMEOUT_CYCLES = 300;
    localparam int HALF           = 20;
    // Clk drop -> sync chain -> byte_strobe -> keycode register.
    localparam int EXP_LAT        = SYNC_STAGES + 2;

    logic Clk;
    logic Reset_n;

    ps2_keycode_rx_if bus_if ();

    ps2_keycode_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus_if.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Pulse counters, sampled away from the active edge.
    always @(negedge Clk) begin
        if (bus_if.keycode_valid === 1'b1) valid_cnt++;
        if (bus_if.frame_err === 1'b1)     err_cnt++;
    end

    // One PS/2 bit: data set mid-high, clock low HALF cycles; optionally measures
    // the number of Clk cycles from the clock drop to the keycode change.
    task automatic ps2_bit(input logic d, input bit meas, output int lat);
        logic [7:0] kc0;
        lat = -1;
        @(negedge Clk);
        bus_if.ps2_data = d;
        repeat (HALF / 2) @(negedge Clk);
        bus_if.ps2_clk = 1'b0;
        kc0 = bus_if.keycode;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge Clk);
            if (meas && lat < 0 && bus_if.keycode !== kc0) lat = i;
        end
        bus_if.ps2_clk = 1'b1;
        repeat (HALF / 2) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, output int lat);
        logic [10:0] bits;
        int          l;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        lat  = -1;
        for (int i = 0; i < 11; i++) begin
            ps2_bit(bits[i], (i == 10), l);
            if (i == 10) lat = l;
        end
        repeat (5) @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] b);
        int l;
        send_frame(b, 1'b0, l);
    endtask

    task automatic send_partial(input logic [7:0] b, input int nbits);
        int l;
        ps2_bit(1'b0, 1'b0, l);
        for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0, l);
    endtask

    task automatic test_reset;
        bus_if.ps2_clk  = 1'b1;
        bus_if.ps2_data = 1'b1;
        Reset_n = 1'b0;
        repeat (4) @(negedge Clk);
        total_cnt++;
        if (bus_if.keycode !== 8'h00) $display("FAIL reset_keycode: got %h expected 00", bus_if.keycode);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.keycode_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus_if.keycode_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.frame_err !== 1'b0) $display("FAIL reset_err: got %b expected 0", bus_if.frame_err);
        else pass_cnt++;
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_make_w;
        int lat;
        int v0;
        v0 = valid_cnt;
        send_frame(8'h1D, 1'b0, lat);
        total_cnt++;
        if (bus_if.keycode !== 8'h1A) $display("FAIL make_w_code: got %h expected 1a", bus_if.keycode);
        else pass_cnt++;
        total_cnt++;
        if (lat !== EXP_LAT) $display("FAIL make_w_latency: got %0d expected %0d", lat, EXP_LAT);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 1) $display("FAIL make_w_pulses: got %0d expected 1", valid_cnt - v0);
        else pass_cnt++;
    endtask

    task automatic test_typematic;
        int v0;
        int lat;
        send(8'hF0);
        send(8'h1D);
        total_cnt++;
        if (bus_if.keycode !== 8'h00) $display("FAIL typ_pre_release: got %h expected 00", bus_if.keycode);
        else pass_cnt++;
        v0 = valid_cnt;
        for (int i = 0; i < 3; i++) begin
            send(8'h1D);
            total_cnt++;
            if (bus_if.keycode !== 8'h1A) $display("FAIL typ_repeat%0d: got %h expected 1a", i, bus_if.keycode);
            else pass_cnt++;
        end
        send(8'hF0);
        send_frame(8'h1D, 1'b0, lat);
        total_cnt++;
        if (bus_if.keycode !== 8'h00) $display("FAIL typ_break: got %h expected 00", bus_if.keycode);
        else pass_cnt++;
        total_cnt++;
        if (lat !== EXP_LAT) $display("FAIL typ_break_latency: got %0d expected %0d", lat, EXP_LAT);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 2) $display("FAIL typ_pulses: got %0d expected 2", valid_cnt - v0);
        else pass_cnt++;
    endtask

    task automatic test_multi_key;
        int v0;
        send(8'h1C);
        total_cnt++;
        if (bus_if.keycode !== 8'h04) $display("FAIL multi_a: got %h expected 04", bus_if.keycode);
        else pass_cnt++;
        send(8'h23);
        total_cnt++;
        if (bus_if.keycode !== 8'h07) $display("FAIL multi_d: got %h expected 07", bus_if.keycode);
        else pass_cnt++;
        v0 = valid_cnt;
        send(8'hF0);
        send(8'h1C);
        total_cnt++;
        if (bus_if.keycode !== 8'h07) $display("FAIL multi_rel_other: got %h expected 07", bus_if.keycode);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 0) $display("FAIL multi_rel_pulses: got %0d expected 0", valid_cnt - v0);
        else pass_cnt++;
        send(8'hF0);
        send(8'h23);
        total_cnt++;
        if (bus_if.keycode !== 8'h00) $display("FAIL multi_rel_d: got %h expected 00", bus_if.keycode);
        else pass_cnt++;
    endtask

    task automatic test_bad_parity;
        int v0;
        int e0;
        int lat;
        send(8'h1C);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h1B, 1'b1, lat);
        total_cnt++;
        if (err_cnt - e0 !== 1) $display("FAIL parity_err: got %0d pulses expected 1", err_cnt - e0);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.keycode !== 8'h04) $display("FAIL parity_code: got %h expected 04", bus_if.keycode);
        else pass_cnt++;
        send(8'hE0);
        send(8'h75);
        total_cnt++;
        if (bus_if.keycode !== 8'h04) $display("FAIL ext_code: got %h expected 04", bus_if.keycode);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 0) $display("FAIL parity_ext_pulses: got %0d expected 0", valid_cnt - v0);
        else pass_cnt++;
        // A pending break must not survive a corrupted frame.
        send(8'hF0);
        send_frame(8'h1C, 1'b1, lat);
        send(8'h1C);
        total_cnt++;
        if (bus_if.keycode !== 8'h04) $display("FAIL err_clears_break: got %h expected 04", bus_if.keycode);
        else pass_cnt++;
    endtask

    task automatic test_timeout;
        int e0;
        int v0;
        e0 = err_cnt;
        send_partial(8'h1B, 5);
        repeat (TIMEOUT_CYCLES - 60) @(negedge Clk);
        total_cnt++;
        if (err_cnt - e0 !== 0) $display("FAIL timeout_early: got %0d pulses expected 0", err_cnt - e0);
        else pass_cnt++;
        repeat (80) @(negedge Clk);
        total_cnt++;
        if (err_cnt - e0 !== 1) $display("FAIL timeout_err: got %0d pulses expected 1", err_cnt - e0);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.keycode !== 8'h04) $display("FAIL timeout_code: got %h expected 04", bus_if.keycode);
        else pass_cnt++;
        v0 = valid_cnt;
        send(8'h1B);
        total_cnt++;
        if (bus_if.keycode !== 8'h16) $display("FAIL timeout_next: got %h expected 16", bus_if.keycode);
        else pass_cnt++;
        total_cnt++;
        if (valid_cnt - v0 !== 1) $display("FAIL timeout_next_pulses: got %0d expected 1", valid_cnt - v0);
        else pass_cnt++;
    endtask

    task automatic test_start_err;
        int e0;
        int l;
        e0 = err_cnt;
        ps2_bit(1'b1, 1'b0, l);
        repeat (5) @(negedge Clk);
        total_cnt++;
        if (err_cnt - e0 !== 1) $display("FAIL start_err: got %0d pulses expected 1", err_cnt - e0);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.keycode !== 8'h16) $display("FAIL start_err_code: got %h expected 16", bus_if.keycode);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame;
        send_partial(8'h1C, 3);
        @(negedge Clk);
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        total_cnt++;
        if (bus_if.keycode !== 8'h00) $display("FAIL midreset_code: got %h expected 00", bus_if.keycode);
        else pass_cnt++;
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
        send(8'h1D);
        total_cnt++;
        if (bus_if.keycode !== 8'h1A) $display("FAIL midreset_next: got %h expected 1a", bus_if.keycode);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_make_w();
        test_typematic();
        test_multi_key();
        test_bad_parity();
        test_timeout();
        test_start_err();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
